// File: rtl/scroll_down.sv
// rtl/scroll_down.sv - reverse-scroll engine: shifts a VRAM text region down one line
//
// Moves rows FIRST_LINE..LAST_LINE-1 of the region down by one row, discards
// the old bottom row and fills FIRST_LINE with FILL_CHAR. Work proceeds from the
// bottom row upwards, so every source row is read before it is overwritten.
// All state changes happen on the falling edge of i_clk, which gives the VRAM
// (sampling on the rising edge) a stable address/data half-cycle.
//
// Ports:
//   i_clk        clock (state on falling edge)
//   i_rst        asynchronous active-high reset, aborts an in-flight scroll
//   i_start      level start request, sampled only in IDLE
//   o_running    high while this block owns the VRAM port
//   o_done       one-cycle pulse after the last write
//   o_cur_row    cursor hint row (FIRST_LINE when not running)
//   o_cur_col    cursor hint col (FIRST_COL when not running)
//   o_vram_addr  VRAM address {row[4:0], col[5:0]}
//   o_vram_ce    VRAM chip enable
//   o_vram_w     VRAM write enable
//   i_vram_dout  VRAM registered read data
//   o_vram_din   VRAM write data
module scroll_down #(
    parameter logic [4:0] FIRST_LINE = 5'd0,
    parameter logic [4:0] LAST_LINE  = 5'd16,
    parameter logic [5:0] FIRST_COL  = 6'd0,
    parameter logic [5:0] LAST_COL   = 6'd59,
    parameter logic [7:0] FILL_CHAR  = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_running,
    output logic        o_done,
    output logic [4:0]  o_cur_row,
    output logic [5:0]  o_cur_col,
    output logic [10:0] o_vram_addr,
    output logic        o_vram_ce,
    output logic        o_vram_w,
    input  logic [7:0]  i_vram_dout,
    output logic [7:0]  o_vram_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] row, row_nxt;
    logic [5:0] col, col_nxt;
    logic [4:0] row_m1;

    // Source row for the current destination row; row is always above
    // FIRST_LINE whenever this is used, so it never wraps.
    assign row_m1 = row - 5'd1;

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            row   <= LAST_LINE;
            col   <= FIRST_COL;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;
        o_running   = 1'b0;
        o_done      = 1'b0;
        o_vram_ce   = 1'b0;
        o_vram_w    = 1'b0;
        o_vram_addr = 11'd0;
        o_vram_din  = 8'd0;
        o_cur_row   = FIRST_LINE;
        o_cur_col   = FIRST_COL;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    col_nxt = FIRST_COL;
                    // A one-line region has nothing to move: go straight to the fill.
                    if (LAST_LINE == FIRST_LINE) begin
                        state_nxt = S_CLEAR;
                        row_nxt   = FIRST_LINE;
                    end else begin
                        state_nxt = S_READ;
                        row_nxt   = LAST_LINE;
                    end
                end
            end

            S_READ: begin
                o_running   = 1'b1;
                o_vram_ce   = 1'b1;
                o_vram_addr = {row_m1, col};
                o_cur_row   = row;
                o_cur_col   = col;
                state_nxt   = S_WRITE;
            end

            S_WRITE: begin
                // Read data from the previous cycle's address is passed straight through.
                o_running   = 1'b1;
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {row, col};
                o_vram_din  = i_vram_dout;
                o_cur_row   = row;
                o_cur_col   = col;
                if (col == LAST_COL) begin
                    col_nxt = FIRST_COL;
                    row_nxt = row_m1;
                    if (row_m1 == FIRST_LINE) begin
                        state_nxt = S_CLEAR;
                    end else begin
                        state_nxt = S_READ;
                    end
                end else begin
                    col_nxt   = col + 6'd1;
                    state_nxt = S_READ;
                end
            end

            S_CLEAR: begin
                o_running   = 1'b1;
                o_vram_ce   = 1'b1;
                o_vram_w    = 1'b1;
                o_vram_addr = {FIRST_LINE, col};
                o_vram_din  = FILL_CHAR;
                o_cur_row   = FIRST_LINE;
                o_cur_col   = col;
                if (col == LAST_COL) begin
                    col_nxt   = FIRST_COL;
                    state_nxt = S_DONE;
                end else begin
                    col_nxt = col + 6'd1;
                end
            end

            S_DONE: begin
                o_done    = 1'b1;
                row_nxt   = LAST_LINE;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scroll_down.sv
// tb/tb_scroll_down.sv - testbench for scroll_down
module tb_scroll_down;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        int repulse_at;
        int reset_at;
        int exp_lat;
        int exp_writes;
    } scen_t;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] val;
    } spot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_mem = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        a_running, a_done, a_ce, a_w;
    logic [4:0]  a_cur_row;
    logic [5:0]  a_cur_col;
    logic [10:0] a_addr;
    logic [7:0]  a_dout, a_din;

    logic        b_running, b_done, b_ce, b_w;
    logic [4:0]  b_cur_row;
    logic [5:0]  b_cur_col;
    logic [10:0] b_addr;
    logic [7:0]  b_dout, b_din;

    logic [7:0] mem_a [2048];
    logic [7:0] mem_b [2048];
    logic [7:0] model_a [2048];

    wr_t exp_a[$];
    wr_t exp_b[$];

    int total = 0;
    int bad = 0;
    int wr_a = 0;
    int wr_b = 0;
    int rd_b = 0;

    always #5 clk = ~clk;

    scroll_down dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a),
        .o_running(a_running), .o_done(a_done),
        .o_cur_row(a_cur_row), .o_cur_col(a_cur_col),
        .o_vram_addr(a_addr), .o_vram_ce(a_ce), .o_vram_w(a_w),
        .i_vram_dout(a_dout), .o_vram_din(a_din)
    );

    scroll_down #(
        .FIRST_LINE(5'd3), .LAST_LINE(5'd3),
        .FIRST_COL(6'd10), .LAST_COL(6'd12),
        .FILL_CHAR(8'h20)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b),
        .o_running(b_running), .o_done(b_done),
        .o_cur_row(b_cur_row), .o_cur_col(b_cur_col),
        .o_vram_addr(b_addr), .o_vram_ce(b_ce), .o_vram_w(b_w),
        .i_vram_dout(b_dout), .o_vram_din(b_din)
    );

    // VRAM models: synchronous write, registered read.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 2048; i++) begin
                mem_a[i] <= i[7:0];
                mem_b[i] <= 8'hAA;
            end
        end else begin
            if (a_ce) begin
                if (a_w) mem_a[a_addr] <= a_din;
                a_dout <= mem_a[a_addr];
            end
            if (b_ce) begin
                if (b_w) mem_b[b_addr] <= b_din;
                b_dout <= mem_b[b_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at the rising edge, when the VRAM samples the port.
    task automatic mon_a();
        wr_t e;
        if (a_w) begin
            wr_a++;
            chk("a_w_implies_ce_running", {31'd0, a_ce & a_running}, 32'd1);
            if (exp_a.size() == 0) begin
                chk("a_extra_write", {21'd0, a_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_a.pop_front();
                chk("a_write", {13'd0, a_addr, a_din}, {13'd0, e.addr, e.data});
                model_a[e.addr] = e.data;
            end
        end
        if (a_ce) begin
            chk("a_addr_in_region",
                {31'd0, (a_addr[10:6] <= 5'd16) && (a_addr[5:0] <= 6'd59)}, 32'd1);
        end
    endtask

    task automatic mon_b();
        wr_t e;
        if (b_ce && !b_w) rd_b++;
        if (b_w) begin
            wr_b++;
            chk("b_w_implies_ce_running", {31'd0, b_ce & b_running}, 32'd1);
            if (exp_b.size() == 0) begin
                chk("b_extra_write", {21'd0, b_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_b.pop_front();
                chk("b_write", {13'd0, b_addr, b_din}, {13'd0, e.addr, e.data});
            end
        end
        if (b_ce) begin
            chk("b_addr_in_region",
                {31'd0, (b_addr[10:6] == 5'd3) && (b_addr[5:0] >= 6'd10) && (b_addr[5:0] <= 6'd12)}, 32'd1);
        end
    endtask

    // Expected write stream for one default-region scroll, from the current model.
    task automatic build_a();
        wr_t e;
        for (int r = 16; r >= 1; r--) begin
            for (int c = 0; c <= 59; c++) begin
                e.addr = 11'(r * 64 + c);
                e.data = model_a[(r - 1) * 64 + c];
                exp_a.push_back(e);
            end
        end
        for (int c = 0; c <= 59; c++) begin
            e.addr = 11'(c);
            e.data = 8'h00;
            exp_a.push_back(e);
        end
    endtask

    task automatic check_mem_a(input string nm);
        int mism = 0;
        for (int i = 0; i < 2048; i++) begin
            if (mem_a[i] !== model_a[i]) mism++;
        end
        chk(nm, mism, 0);
    endtask

    // Entered at rising edge + 1; returns at rising edge + 1.
    task automatic run_a(input scen_t s, output int lat, output int nrun);
        lat  = -1;
        nrun = 0;
        wr_a = 0;
        start_a = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 2500; k++) begin
            if (k > 0) @(negedge clk);
            @(posedge clk);
            mon_a();
            if (a_running) nrun++;
            if (a_done && lat < 0) lat = k;
            #1;
            if (k == 0) start_a = 1'b0;
            if (k == s.repulse_at) start_a = 1'b1;
            if (s.repulse_at >= 0 && k == s.repulse_at + 1) start_a = 1'b0;
            if (k == s.reset_at) begin
                rst = 1'b1;
                #1;
                chk("abort_running", {31'd0, a_running}, 32'd0);
                chk("abort_ce", {31'd0, a_ce}, 32'd0);
                chk("abort_w", {31'd0, a_w}, 32'd0);
                exp_a.delete();
                #1;
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk);
                    mon_a();
                end
                #1;
                break;
            end
            if (lat >= 0) begin
                @(negedge clk);
                @(posedge clk);
                mon_a();
                chk("done_single_pulse", {31'd0, a_done}, 32'd0);
                chk("idle_cur_row", {27'd0, a_cur_row}, 32'd0);
                chk("idle_cur_col", {26'd0, a_cur_col}, 32'd0);
                #1;
                break;
            end
        end
    endtask

    scen_t scen [4];
    spot_t spot [10];

    initial begin
        int lat, nrun, b_lat;

        scen[0] = '{-1,  -1, 1980, 1020};
        scen[1] = '{300, -1, 1980, 1020};
        scen[2] = '{-1, 500,   -1,  250};
        scen[3] = '{-1,  -1, 1980, 1020};

        // Values after one scroll from cell{r,c} = r*64+c.
        spot[0] = '{0,  0,  8'h00};
        spot[1] = '{0,  59, 8'h00};
        spot[2] = '{0,  60, 8'h3C};
        spot[3] = '{1,  0,  8'h00};
        spot[4] = '{1,  5,  8'h05};
        spot[5] = '{5,  10, 8'h0A};
        spot[6] = '{8,  30, 8'hDE};
        spot[7] = '{16, 59, 8'hFB};
        spot[8] = '{16, 63, 8'h3F};
        spot[9] = '{17, 0,  8'h40};

        for (int i = 0; i < 2048; i++) model_a[i] = i[7:0];

        repeat (3) @(posedge clk);
        chk("rst_running", {31'd0, a_running}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_ce", {31'd0, a_ce}, 32'd0);
        chk("rst_w", {31'd0, a_w}, 32'd0);
        chk("rst_addr", {21'd0, a_addr}, 32'd0);
        chk("rst_din", {24'd0, a_din}, 32'd0);
        chk("rst_cur_row", {27'd0, a_cur_row}, 32'd0);
        chk("rst_cur_col", {26'd0, a_cur_col}, 32'd0);
        chk("rst_b_cur_row", {27'd0, b_cur_row}, 32'd3);
        chk("rst_b_cur_col", {26'd0, b_cur_col}, 32'd10);
        #1;
        rst = 1'b0;
        init_mem = 1'b0;
        @(posedge clk);
        #1;

        for (int s = 0; s < 4; s++) begin
            build_a();
            run_a(scen[s], lat, nrun);
            chk($sformatf("s%0d_writes", s), wr_a, scen[s].exp_writes);
            if (scen[s].reset_at < 0) begin
                chk($sformatf("s%0d_latency", s), lat, scen[s].exp_lat);
                chk($sformatf("s%0d_running_cycles", s), nrun, scen[s].exp_lat);
                chk($sformatf("s%0d_queue_empty", s), exp_a.size(), 0);
            end
            check_mem_a($sformatf("s%0d_vram", s));
            if (s == 0) begin
                for (int i = 0; i < 10; i++) begin
                    chk($sformatf("spot_r%0d_c%0d", spot[i].row, spot[i].col),
                        {24'd0, mem_a[spot[i].row * 64 + spot[i].col]}, {24'd0, spot[i].val});
                end
            end
            repeat (2) @(posedge clk);
            #1;
        end

        // Single-line region: fill only, no reads.
        begin
            wr_t e;
            for (int c = 10; c <= 12; c++) begin
                e.addr = 11'(3 * 64 + c);
                e.data = 8'h20;
                exp_b.push_back(e);
            end
        end
        b_lat = -1;
        start_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            @(posedge clk);
            mon_b();
            if (b_done) b_lat = k;
            #1;
            start_b = 1'b0;
            if (b_lat >= 0) break;
        end
        chk("b_latency", b_lat, 3);
        chk("b_writes", wr_b, 3);
        chk("b_reads", rd_b, 0);
        chk("b_queue_empty", exp_b.size(), 0);
        @(posedge clk);
        #1;
        chk("b_cell_201", {24'd0, mem_b[201]}, 32'hAA);
        chk("b_cell_202", {24'd0, mem_b[202]}, 32'h20);
        chk("b_cell_204", {24'd0, mem_b[204]}, 32'h20);
        chk("b_cell_205", {24'd0, mem_b[205]}, 32'hAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
